// File: rtl/demux1x2_buffered_pkg.sv
// Shared constants and types for the buffered 1-to-2 demultiplexer.
package demux1x2_buffered_pkg;

  localparam int DEMUX_WIDTH_DEFAULT = 4;
  localparam int DEMUX_DEPTH         = 2;

  // Destination select encoding carried on in_sel.
  typedef enum logic {
    SEL_OUT0 = 1'b0,
    SEL_OUT1 = 1'b1
  } demux_sel_e;

  // Occupancy at which a buffer refuses further pushes.
  localparam logic [1:0] FIFO_FULL_COUNT = 2'(DEMUX_DEPTH);

endpackage

// File: rtl/demux1x2_buffered_fifo2x4.sv
// Two-entry FIFO with 1-bit wrapping pointers and a 0..2 occupancy count.
// Pushes into a full buffer and pops from an empty buffer are ignored, so
// the count can never leave its legal range.
module fifo2x4
  import demux1x2_buffered_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [DEMUX_DEPTH];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full      = (count_q == FIFO_FULL_COUNT);
  assign empty     = (count_q == 2'd0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  // Full is checked against the registered count, so a pop in the same
  // cycle never frees room for a push.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Next pointer and occupancy values from the qualified push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Pointer, count and storage registers; reset flushes everything to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int i = 0; i < DEMUX_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data;
      end
    end
  end

endmodule

// File: rtl/demux1x2_buffered.sv
// Buffered 1-to-2 demultiplexer: routes one producer's words to one of two
// independently stalling consumers, each behind its own 2-entry FIFO.
// in_ready depends only on registered occupancy and in_sel, never on the
// consumer ready inputs.
module demux1x2_buffered
  import demux1x2_buffered_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [1:0]       count0,
  output logic [1:0]       count1
);

  logic full0, full1;
  logic empty0, empty1;
  logic push0, push1;
  logic pop0, pop1;

  // Push decode: only the selected, non-full buffer takes the word.
  assign push0 = in_valid & (in_sel == SEL_OUT0) & ~full0;
  assign push1 = in_valid & (in_sel == SEL_OUT1) & ~full1;

  // Pop decode: a ready with nothing buffered is ignored.
  assign pop0 = out0_valid & out0_ready;
  assign pop1 = out1_valid & out1_ready;

  assign in_ready   = (in_sel == SEL_OUT1) ? ~full1 : ~full0;
  assign out0_valid = ~empty0;
  assign out1_valid = ~empty1;

  fifo2x4 #(.WIDTH(WIDTH)) u_fifo0 (
    .clk       (clk),
    .reset     (reset),
    .push      (push0),
    .push_data (in_data),
    .full      (full0),
    .pop       (pop0),
    .head_data (out0_data),
    .empty     (empty0),
    .count     (count0)
  );

  fifo2x4 #(.WIDTH(WIDTH)) u_fifo1 (
    .clk       (clk),
    .reset     (reset),
    .push      (push1),
    .push_data (in_data),
    .full      (full1),
    .pop       (pop1),
    .head_data (out1_data),
    .empty     (empty1),
    .count     (count1)
  );

endmodule

// File: tb/tb_demux1x2_buffered.sv
// Directed bench for demux1x2_buffered: reset, routing, backpressure,
// ordering under stall, simultaneous push/pop and reset mid-operation.
module tb_demux1x2_buffered;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in_data;
  logic       in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] out0_data, out1_data;
  logic       out0_valid, out1_valid;
  logic       out0_ready, out1_ready;
  logic [1:0] count0, count1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  demux1x2_buffered #(.WIDTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .count0     (count0),
    .count1     (count1)
  );

  // Advance one rising edge; inputs and checks happen 1 time unit later.
  task automatic tick(input string what);
    @(posedge clk);
    #1;
    $display("step %-28s valid=%0b sel=%0b data=%h rdy0=%0b rdy1=%0b -> c0=%0d c1=%0d o0=%h o1=%h",
             what, in_valid, in_sel, in_data, out0_ready, out1_ready,
             count0, count1, out0_data, out1_data);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b1; in_data = 4'hF; in_sel = 1'b0;
    out0_ready = 1'b0; out1_ready = 1'b0;

    // Reset held two cycles while a push is offered.
    #1;
    tick("reset1");
    tick("reset2");
    reset = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_count0", 8'(count0), 8'd0);
    chk("rst_count1", 8'(count1), 8'd0);
    chk("rst_valid0", 8'(out0_valid), 8'd0);
    chk("rst_valid1", 8'(out1_valid), 8'd0);
    chk("rst_data0",  8'(out0_data), 8'h0);
    chk("rst_data1",  8'(out1_data), 8'h0);
    chk("rst_in_ready", 8'(in_ready), 8'd1);

    // Basic routing.
    in_valid = 1'b1; in_data = 4'hA; in_sel = 1'b0;
    tick("push A->out0");
    chk("route_data0",  8'(out0_data), 8'hA);
    chk("route_count0", 8'(count0), 8'd1);
    chk("route_valid0", 8'(out0_valid), 8'd1);
    chk("route_count1_idle", 8'(count1), 8'd0);
    in_data = 4'h5; in_sel = 1'b1;
    tick("push 5->out1");
    in_valid = 1'b0;
    chk("route_data1",  8'(out1_data), 8'h5);
    chk("route_count1", 8'(count1), 8'd1);
    chk("route_count0_hold", 8'(count0), 8'd1);

    // Drain both.
    out0_ready = 1'b1; out1_ready = 1'b1;
    tick("pop both");
    out0_ready = 1'b0; out1_ready = 1'b0;
    #1;
    chk("drain_count0", 8'(count0), 8'd0);
    chk("drain_count1", 8'(count1), 8'd0);

    // Ready on an empty buffer is ignored.
    out1_ready = 1'b1;
    tick("pop empty out1");
    out1_ready = 1'b0;
    chk("empty_pop_count1", 8'(count1), 8'd0);

    // Full / backpressure.
    in_valid = 1'b1; in_sel = 1'b0; in_data = 4'h1;
    tick("push 1->out0");
    in_data = 4'h2;
    tick("push 2->out0");
    chk("full_count0", 8'(count0), 8'd2);
    in_data = 4'h3;
    #1;
    chk("full_in_ready", 8'(in_ready), 8'd0);
    tick("push 3->out0 blocked");
    chk("blocked_count0", 8'(count0), 8'd2);
    chk("blocked_head0", 8'(out0_data), 8'h1);
    in_sel = 1'b1;
    #1;
    chk("other_in_ready", 8'(in_ready), 8'd1);
    tick("push 3->out1");
    in_valid = 1'b0;
    chk("redirect_count1", 8'(count1), 8'd1);
    chk("redirect_data1", 8'(out1_data), 8'h3);

    // Full buffer refuses a push even while popping.
    in_valid = 1'b1; in_sel = 1'b0; in_data = 4'h9; out0_ready = 1'b1;
    #1;
    chk("full_pop_in_ready", 8'(in_ready), 8'd0);
    in_valid = 1'b0; out0_ready = 1'b0;

    // Ordering and stall.
    for (int k = 0; k < 3; k++) begin
      tick("stall out0");
      chk("stall_head0", 8'(out0_data), 8'h1);
      chk("stall_count0", 8'(count0), 8'd2);
    end
    out0_ready = 1'b1;
    tick("pop out0 (1)");
    chk("order_head0", 8'(out0_data), 8'h2);
    chk("order_count0", 8'(count0), 8'd1);
    tick("pop out0 (2)");
    out0_ready = 1'b0;
    chk("order_valid0", 8'(out0_valid), 8'd0);
    chk("order_empty0", 8'(count0), 8'd0);
    out1_ready = 1'b1;
    tick("pop out1");
    out1_ready = 1'b0;
    chk("pop1_count1", 8'(count1), 8'd0);

    // Simultaneous push/pop on out0.
    in_valid = 1'b1; in_sel = 1'b0; in_data = 4'h7;
    tick("push 7->out0");
    chk("simul_pre_count0", 8'(count0), 8'd1);
    in_data = 4'h8; out0_ready = 1'b1;
    tick("push 8 + pop out0");
    chk("simul_count0", 8'(count0), 8'd1);
    chk("simul_head0", 8'(out0_data), 8'h8);
    // Push out1 while popping out0.
    in_sel = 1'b1; in_data = 4'h6;
    tick("push 6->out1 + pop out0");
    in_valid = 1'b0; out0_ready = 1'b0;
    chk("cross_count0", 8'(count0), 8'd0);
    chk("cross_count1", 8'(count1), 8'd1);
    chk("cross_data1", 8'(out1_data), 8'h6);

    // Reset mid-operation.
    in_valid = 1'b1; in_sel = 1'b0; in_data = 4'hD;
    tick("push D->out0");
    in_data = 4'hE;
    tick("push E->out0");
    chk("pre_rst_count0", 8'(count0), 8'd2);
    chk("pre_rst_count1", 8'(count1), 8'd1);
    reset = 1'b1; in_sel = 1'b1; in_data = 4'hB; out0_ready = 1'b1;
    tick("reset with push/pop");
    reset = 1'b0; in_valid = 1'b0; out0_ready = 1'b0;
    chk("mid_rst_count0", 8'(count0), 8'd0);
    chk("mid_rst_count1", 8'(count1), 8'd0);
    chk("mid_rst_valid1", 8'(out1_valid), 8'd0);
    chk("mid_rst_data0", 8'(out0_data), 8'h0);
    tick("idle after reset");
    chk("post_rst_valid0", 8'(out0_valid), 8'd0);
    chk("post_rst_valid1", 8'(out1_valid), 8'd0);
    in_valid = 1'b1; in_sel = 1'b0; in_data = 4'hC;
    tick("push C->out0");
    in_valid = 1'b0;
    chk("post_rst_data0", 8'(out0_data), 8'hC);
    chk("post_rst_count0", 8'(count0), 8'd1);
    chk("post_rst_valid0b", 8'(out0_valid), 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
